fwd_hazard_unit: RTL
====================

// Module: fwd_hazard_unit
// PURPOSE
//  Producer of the EX-stage forwarding selects and the load-use stall. Tracks the destination tags of
//  the instructions in EX and MEM, compares them with the sources of the instruction in decode, and
//  registers aluselectA/aluselectB so they are valid in the same cycle that instruction sits in EX.
//  Its stall output drives the EX pipeline-register bubble and the IF/ID hold.
// PARAMETERS
//  LOAD_LAT  1   stall cycles per load-use hazard, legal range 1..3
//  CNT_W     16  width of the stall statistics counter
// PORTS
//  clk           in   1      rising-edge clock
//  reset         in   1      asynchronous, active-high reset
//  id_valid      in   1      decode slot holds a real instruction
//  id_rs         in   5      source register A of decode instruction
//  id_rt         in   5      source register B of decode instruction
//  id_use_rs     in   1      instruction reads id_rs through BusA
//  id_use_rt     in   1      instruction reads id_rt through BusB
//  id_rw         in   5      destination register of decode instruction
//  id_regwrite   in   1      decode instruction writes id_rw
//  id_memtoreg   in   1      decode instruction is a load
//  stall         out  1      combinational: insert bubble into EX, hold IF/ID
//  aluselectA    out  2      registered select for EX operand A
//  aluselectB    out  2      registered select for EX operand B
//  stall_count   out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
//  Select encoding: 00 = register-file bus, 01 = priorALUresult (distance 1),
//   10 = ALUwriteback (distance 2), 11 = reserved, never driven.
//  Tag pipeline: ex_tag, then mem_tag, each holding {valid, regwrite, load, rw}. Every posedge:
//   mem_tag <= ex_tag; ex_tag <= stall ? bubble (all zero) : {id_valid, id_regwrite, id_memtoreg, id_rw}.
//  Match rule: match(t, r) = t.valid & t.regwrite & (t.rw != 0) & (t.rw == r). Register r0 is never
//   forwarded.
//  Select calc for A (B is identical with id_rt/id_use_rt): if !id_use_rs or stall, 00;
//   else if match(ex_tag, id_rs), 01; else if match(mem_tag, id_rs), 10; else 00.
//   Distance 1 wins over distance 2. The result is registered at the same edge EX captures the
//   instruction, so latency is 1 cycle.
//  Hazard: RUN & id_valid & ex_tag.load & ((id_use_rs & match(ex_tag, id_rs)) |
//   (id_use_rt & match(ex_tag, id_rt))).
//  FSM:
//   RUN: stall = hazard. On hazard with LOAD_LAT == 1, stay in RUN (one bubble only).
//        On hazard with LOAD_LAT > 1, go to LDSTALL with cnt <= LOAD_LAT-1.
//   LDSTALL: stall = 1, cnt decrements each cycle, return to RUN at the edge where cnt == 1.
//   Total bubbles per hazard = LOAD_LAT. The hazard is evaluated only in RUN.
//   After the bubbles the load has advanced: distance 2 gives 10; distance 3 or more gives 00
//   (register file).
//  stall_count increments on every cycle stall = 1 and saturates at all-ones.
//  Reset (asynchronous, any time, including mid-LDSTALL):
//   - tags cleared, FSM = RUN, cnt = 0, aluselectA/B = 00, stall_count = 0;
//   - stall is therefore 0 while reset is high.
//  A non-load producer at distance 1 never stalls. Loads with id_use_* = 0 never stall.
//  When rs == rt, both selects are equal.
// STRUCTURE
//  Shared package (pipe_pkg): SEL_BUS/SEL_PRIOR/SEL_WB localparams, tag struct/field widths.
//  One sub-module, hazard_tag_stage: a resettable tag register with bubble insert, instantiated
//  twice (EX and MEM).
//  FSM, comparators and counter stay in the top.
// TESTING
//  1. add r3 then add r4,r3,r5 back-to-back -> aluselectA = 01 in consumer's EX cycle, stall never 1.
//  2. add r3, nop, sub r6,r2,r3 -> aluselectB = 10; with 2 nops -> 00.
//  3. lw r7 then add r8,r7,r1, LOAD_LAT = 1 -> stall = 1 exactly one cycle, then aluselectA = 10,
//     stall_count = 1.
//  4. Same as 3 with LOAD_LAT = 3 -> stall high 3 cycles, then aluselectA = 00, stall_count = 3.
//  5. Producer writes r0, consumer reads r0 -> selects 00, no stall. Distance-1 and distance-2
//     producers both write r9 -> 01.
//  6. Assert reset during the 2nd cycle of a LOAD_LAT = 3 stall -> stall, selects, stall_count = 0
//     immediately; next instruction flows in RUN.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the EX forwarding / load-use hazard unit.
// Select codes, destination-tag bundle, FSM states, tag match helper.
package pipe_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] SEL_BUS   = 2'b00;
  localparam logic [1:0] SEL_PRIOR = 2'b01;
  localparam logic [1:0] SEL_WB    = 2'b10;

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             load;
    logic [REG_W-1:0] rw;
  } tag_t;

  typedef enum logic {
    RUN,
    LDSTALL
  } hz_state_e;

  // r0 is hard-wired zero, so it is never a forwarding source
  function automatic logic tag_match(
    input tag_t             t,
    input logic [REG_W-1:0] r
  );
    return t.valid & t.regwrite &
           (t.rw != '0) & (t.rw == r);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Decode-slot operands in, stall / forwarding selects / stats out.
// master = decode side, slave = hazard unit.
interface fwd_hazard_unit_if #(
  parameter int CNT_W = 16
);
  import pipe_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] id_rw;
  logic             id_regwrite;
  logic             id_memtoreg;
  logic             stall;
  logic [1:0]       aluselectA;
  logic [1:0]       aluselectB;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt,
    output id_use_rs, id_use_rt,
    output id_rw, id_regwrite, id_memtoreg,
    input  stall, aluselectA, aluselectB,
    input  stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt,
    input  id_use_rs, id_use_rt,
    input  id_rw, id_regwrite, id_memtoreg,
    output stall, aluselectA, aluselectB,
    output stall_count
  );

endinterface

// File: rtl/hazard_tag_stage.sv
// One pipeline slot of destination tags; bubble loads all-zero.
// Ports: clk, reset (async high), bubble, din, dout.
module hazard_tag_stage
  import pipe_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic bubble,
  input  tag_t din,
  output tag_t dout
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= '0;
    end else begin
      dout <= bubble ? tag_t'('0) : din;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX forwarding selects and load-use stall with LOAD_LAT bubbles.
// Ports: clk, reset (async high), bus (decode operands / stall, selects, stats).
module fwd_hazard_unit
  import pipe_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic              clk,
  input logic              reset,
  fwd_hazard_unit_if.slave bus
);

  localparam logic [1:0] LD_INIT = 2'(LOAD_LAT - 1);

  tag_t       idTag;
  tag_t       exTag;
  tag_t       memTag;
  hz_state_e  state;
  hz_state_e  stateNext;
  logic [1:0] cnt;
  logic [1:0] cntNext;
  logic       stall;
  logic       hazard;
  logic [1:0] selANext;
  logic [1:0] selBNext;
  logic [1:0] selA;
  logic [1:0] selB;
  logic [CNT_W-1:0] statCnt;

  function automatic logic [1:0] sel_for(
    input logic             useR,
    input logic [REG_W-1:0] r,
    input tag_t             ex,
    input tag_t             mem,
    input logic             stl
  );
    logic [1:0] s;
    s = SEL_BUS;
    if (useR && !stl) begin
      if (tag_match(ex, r)) begin
        s = SEL_PRIOR;
      end else if (tag_match(mem, r)) begin
        s = SEL_WB;
      end
    end
    return s;
  endfunction

  assign idTag = '{
    valid:    bus.id_valid,
    regwrite: bus.id_regwrite,
    load:     bus.id_memtoreg,
    rw:       bus.id_rw
  };

  hazard_tag_stage u_ex (
    .clk    (clk),
    .reset  (reset),
    .bubble (stall),
    .din    (idTag),
    .dout   (exTag)
  );

  hazard_tag_stage u_mem (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .din    (exTag),
    .dout   (memTag)
  );

  assign hazard = bus.id_valid & exTag.load &
    ((bus.id_use_rs & tag_match(exTag, bus.id_rs)) |
     (bus.id_use_rt & tag_match(exTag, bus.id_rt)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Hazard is only looked at in RUN; LDSTALL just counts bubbles
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    stall     = 1'b0;
    unique case (state)
      RUN: begin
        stall = hazard;
        if (hazard && LOAD_LAT > 1) begin
          stateNext = LDSTALL;
          cntNext   = LD_INIT;
        end
      end
      LDSTALL: begin
        stall   = 1'b1;
        cntNext = cnt - 2'd1;
        if (cnt == 2'd1) begin
          stateNext = RUN;
        end
      end
    endcase
  end

  assign selANext = sel_for(bus.id_use_rs,
    bus.id_rs, exTag, memTag, stall);
  assign selBNext = sel_for(bus.id_use_rt,
    bus.id_rt, exTag, memTag, stall);

  // Captured at the edge EX takes the instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      selA    <= SEL_BUS;
      selB    <= SEL_BUS;
      statCnt <= '0;
    end else begin
      selA <= selANext;
      selB <= selBNext;
      if (stall && statCnt != '1) begin
        statCnt <= statCnt + CNT_W'(1);
      end
    end
  end

  assign bus.stall       = stall;
  assign bus.aluselectA  = selA;
  assign bus.aluselectB  = selB;
  assign bus.stall_count = statCnt;

endmodule
